// File: rtl/debounce_edge_detector_if.sv
// Signal bundle between a raw level source and the debounce/edge-detect stage.
// The source side drives the raw level; the conditioning stage returns the
// clean level and its single-cycle edge pulses.
interface debounce_edge_detector_if;
    logic in;    // raw, possibly asynchronous and bouncy level
    logic out;   // debounced, synchronised level
    logic rise;  // one-cycle pulse when out goes 0->1
    logic fall;  // one-cycle pulse when out goes 1->0

    modport master (
        output in,
        input  out,
        input  rise,
        input  fall
    );

    modport slave (
        input  in,
        output out,
        output rise,
        output fall
    );
endinterface

// File: rtl/debounce_edge_detector.sv
// Debounce and edge detector: two-flop synchroniser followed by a four-state
// qualification FSM. The level must be seen for STABLE_CYCLES consecutive
// synchronised samples before out changes; rise/fall are registered pulses
// that line up with the first cycle out shows its new value.
// STABLE_CYCLES must lie in 1 .. 2^CNT_WIDTH-1.
module debounce_edge_detector #(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    debounce_edge_detector_if.slave bus
);

    localparam int SYNC_STAGES = 2;
    localparam bit SINGLE      = (STABLE_CYCLES == 1);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHK_HIGH    = 2'd1,
        STABLE_HIGH = 2'd2,
        CHK_LOW     = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync2;
    state_t                 state_reg, state_next;
    logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
    logic                   out_reg, out_next;
    logic                   rise_reg, rise_next;
    logic                   fall_reg, fall_next;

    // Synchroniser chain: stage 0 samples the raw level, later stages
    // re-register the previous stage. Only the last stage is used downstream.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First synchroniser flop samples the raw input.
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= bus.in;
                end
            end else begin : g_rest
                // Later synchroniser flops shift the previous stage along.
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign sync2 = sync_reg[SYNC_STAGES-1];

    // State register plus registered level and edge outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= STABLE_LOW;
            cnt_reg   <= '0;
            out_reg   <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            out_reg   <= out_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
        end
    end

    // Next-state logic: count agreeing samples, drop back on any disagreement,
    // commit once the run of agreeing samples reaches STABLE_CYCLES.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            STABLE_LOW: begin
                if (sync2) begin
                    if (SINGLE) begin
                        state_next = STABLE_HIGH;
                        cnt_next   = '0;
                    end else begin
                        state_next = CHK_HIGH;
                        cnt_next   = ONE;
                    end
                end
            end
            CHK_HIGH: begin
                if (!sync2) begin
                    state_next = STABLE_LOW;
                    cnt_next   = '0;
                end else if (cnt_reg == LAST) begin
                    state_next = STABLE_HIGH;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + ONE;
                end
            end
            STABLE_HIGH: begin
                if (!sync2) begin
                    if (SINGLE) begin
                        state_next = STABLE_LOW;
                        cnt_next   = '0;
                    end else begin
                        state_next = CHK_LOW;
                        cnt_next   = ONE;
                    end
                end
            end
            CHK_LOW: begin
                if (sync2) begin
                    state_next = STABLE_HIGH;
                    cnt_next   = '0;
                end else if (cnt_reg == LAST) begin
                    state_next = STABLE_LOW;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + ONE;
                end
            end
            default: begin
                state_next = STABLE_LOW;
                cnt_next   = '0;
            end
        endcase
    end

    // Output logic: out is high in STABLE_HIGH and while checking a fall
    // (CHK_LOW); an edge pulse fires only when the committed level changes.
    always_comb begin
        out_next  = (state_next == STABLE_HIGH) || (state_next == CHK_LOW);
        rise_next = out_next & ~out_reg;
        fall_next = ~out_next & out_reg;
    end

    assign bus.out  = out_reg;
    assign bus.rise = rise_reg;
    assign bus.fall = fall_reg;

endmodule

// File: tb/tb_debounce_edge_detector.sv
// Self-checking bench for debounce_edge_detector. A reference model updated
// on each posedge pushes the expected {out,rise,fall} into a queue; a
// separate monitor pops one entry per cycle and compares it with the DUT.
module tb_debounce_edge_detector;

    localparam int N  = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    debounce_edge_detector_if bus();

    debounce_edge_detector #(
        .STABLE_CYCLES(N),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    logic [2:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int cycle = 0;

    // Reference model: the raw level is seen by the decision logic two edges
    // after it is sampled; out flips once N consecutive seen samples all
    // disagree with it, and the flip carries a one-cycle rise or fall.
    bit m_s1   = 1'b0;
    bit m_s2   = 1'b0;
    bit m_out  = 1'b0;
    bit m_rise = 1'b0;
    bit m_fall = 1'b0;
    int m_run  = 0;

    always @(posedge clk) begin : model
        bit seen;
        if (rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_out = 1'b0;
            m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
        end else begin
            seen   = m_s2;
            m_s2   = m_s1;
            m_s1   = bus.in;
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (seen != m_out) begin
                m_run++;
                if (m_run == N) begin
                    m_out  = seen;
                    m_rise = seen;
                    m_fall = !seen;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        exp_q.push_back({m_out, m_rise, m_fall});
    end

    // Monitor: one comparison per cycle, sampled 1 time unit after the edge.
    always @(posedge clk) begin : monitor
        logic [2:0] e;
        logic [2:0] got;
        #1;
        cycle++;
        got = {bus.out, bus.rise, bus.fall};
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty cycle %0d: got out/rise/fall=%b, no expected entry", cycle, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                fails++;
                $display("FAIL outputs cycle %0d: got out/rise/fall=%b required %b (rst=%b in=%b)",
                         cycle, got, e, rst, bus.in);
            end else begin
                $display("[TB] cycle %0d rst=%b in=%b out/rise/fall=%b ok", cycle, rst, bus.in, got);
            end
        end
    end

    // Drive one cycle of stimulus away from the active edge.
    task automatic step(input bit v, input bit r);
        @(negedge clk);
        bus.in = v;
        rst    = r;
    endtask

    task automatic hold(input bit v, input int n);
        for (int k = 0; k < n; k++) step(v, 1'b0);
    endtask

    initial begin
        bus.in = 1'b1;
        rst    = 1'b1;

        // Reset with in=1, then release and let out rise after full latency.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        hold(1'b1, 10);

        // Clean fall then clean rise.
        hold(1'b0, 10);
        hold(1'b1, 10);

        // Bounce rejection starting from out=0.
        hold(1'b0, 10);
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        hold(1'b1, 10);

        // Short low glitch while out=1.
        hold(1'b0, 3);
        hold(1'b1, 10);

        // Reset in the middle of a qualification.
        hold(1'b0, 10);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        hold(1'b1, 10);

        // Randomised runs of varying length with occasional resets.
        for (int seg = 0; seg < 300; seg++) begin
            bit v;
            int len;
            v   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 8));
            if ($urandom_range(0, 49) == 0) step(v, 1'b1);
            hold(v, len);
        end

        hold(bus.in, 3);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d leftover entries required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/debounce_edge_detector.md
Name: debounce_edge_detector

Overview:
- Input conditioning stage that sits directly upstream of the team's D flip-flop and register stages.
- Takes a raw asynchronous or bouncy level, such as a push-button or switch, and synchronises it into the clk domain.
- Filters out bounce by requiring the level to be stable for a programmable number of cycles.
- Outputs a clean level plus single-cycle rise and fall pulses, suitable for driving a flip-flop's data or enable input.

Parameters:
- STABLE_CYCLES, default 50000. Consecutive synchronised samples that must agree before out changes. Legal range 1 .. 2^CNT_WIDTH-1.
- CNT_WIDTH, default 16. Width of the stability counter.

Ports:
- clk  input  1  system clock; all logic on the posedge.
- rst  input  1  synchronous, active-high reset.
- in   input  1  raw level; may be asynchronous to clk and may bounce.
- out  output 1  debounced, synchronised level.
- rise output 1  one-cycle pulse when out goes 0->1.
- fall output 1  one-cycle pulse when out goes 1->0.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high. It is sampled only on posedge clk and has no asynchronous path.
- Reset values, applied at the posedge where rst=1:
  - sync1=0, sync2=0, cnt=0, state=STABLE_LOW.
  - out=0, rise=0, fall=0.
- rst has priority over every other event.
- Synchroniser: two-flop chain, sync1<=in, sync2<=sync1. Only sync2 feeds the FSM; in is never used directly.
- FSM states: STABLE_LOW, CHK_HIGH, STABLE_HIGH, CHK_LOW.
- STABLE_LOW (out=0):
  - sync2=1 -> CHK_HIGH with cnt<=1.
  - If STABLE_CYCLES==1, instead go straight to STABLE_HIGH and commit the change (see commit rule below).
  - Otherwise stay.
- CHK_HIGH:
  - sync2=0 (glitch) -> STABLE_LOW, cnt<=0, no pulse.
  - sync2=1 and cnt==STABLE_CYCLES-1 -> STABLE_HIGH, commit the change.
  - sync2=1 otherwise -> cnt<=cnt+1.
- STABLE_HIGH and CHK_LOW mirror the above with polarities swapped; fall replaces rise.
- Commit rule: out updates at the same edge as the transition into STABLE_HIGH or STABLE_LOW.
  - rise (or fall) is registered and asserted for exactly the one cycle in which out first shows the new value.
  - rise and fall are never both high.
  - Neither pulse occurs without a change in out.
- Latency: let t0 be the first posedge at which sync1 samples the new, thereafter stable, in value. out shows the new value after edge t0+1+STABLE_CYCLES.
  - For STABLE_CYCLES=1 that is edge t0+2.
- Counter never exceeds STABLE_CYCLES-1 and never wraps. cnt is cleared on every return to a STABLE_* state.
- Any disagreeing sample restarts the qualification from zero. Partial counts are never retained.
- Reset mid-qualification: the pending change is abandoned and out=0.
  - If in is 1 when rst deasserts, out rises after the full latency, with a rise pulse.
- in held constant: outputs hold indefinitely, with no pulses.

Test Plan (STABLE_CYCLES=4, CNT_WIDTH=3, clk period 20):
- Reset: rst=1 for 2 edges with in=1 -> out=0, rise=0, fall=0 during reset. After release, out=1 at edge t0+5 with a rise pulse exactly one cycle wide.
- Clean rise: in 0->1 before edge t0, held -> out=0 through edge t0+4, out=1 after edge t0+5, rise=1 for that single cycle only, fall=0 throughout.
- Bounce rejection: in toggles 1,0,1,0 every 20 time units (one clk period), then holds at 1 -> no rise pulse during the bounce. out=1 exactly 5 edges after the first edge at which sync1 samples the final stable 1.
- Short glitch: out=1, in pulses low for 3 cycles (< STABLE_CYCLES + sync) -> out stays 1, fall never asserted.
- Clean fall then rise: in 1->0 held for 10 cycles, then 0->1 -> one fall pulse, then one rise pulse, each exactly 1 cycle; out matches in delayed by 5 edges.
- Reset mid-count: in 0->1, assert rst 2 edges later for one edge -> out stays 0, no rise pulse. Counting restarts after release and out=1 at the full latency from the release.
